// File: rtl/rf_wb_ctrl.sv
// Purpose: arbitrates NREQ write-back requesters onto the single rf write port and keeps a per-register busy scoreboard.
// Latency: accept in cycle N drives write/writeregsel/writedata in N+1; busy clears at the edge ending N+1.
// Backpressure: the commit stage never stalls; exactly one valid requester is granted each cycle. Macro RF_WB_RR_EN selects round-robin.
module rf_wb_ctrl #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*REG_W-1:0]    req_regsel,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic                     rsv_valid,
  input  logic [REG_W-1:0]         rsv_regsel,
  input  logic [REG_W-1:0]         chk1_regsel,
  input  logic [REG_W-1:0]         chk2_regsel,
  output logic                     hazard,
  output logic [(1<<REG_W)-1:0]    busy,
  output logic                     write,
  output logic [REG_W-1:0]         writeregsel,
  output logic [DATA_W-1:0]        writedata
);

  localparam int NREG = 1 << REG_W;

  // Isolates the lowest set bit: the lowest-index valid requester wins.
  function automatic logic [NREQ-1:0] lowest_set(input logic [NREQ-1:0] v);
    return v & (~v + NREQ'(1));
  endfunction

  logic                accept;
  logic [REG_W-1:0]    win_regsel;
  logic [DATA_W-1:0]   win_data;
  logic [NREG-1:0]     busy_nxt;

`ifdef RF_WB_RR_EN
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_ptr_nxt;
  logic [NREQ-1:0]  above_mask;
  logic [NREQ-1:0]  masked_valid;

  // Round-robin grant: prefer valid requesters above the pointer, else wrap to the lowest valid one.
  always_comb begin
    above_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      above_mask[i] = (PTR_W'(i) > rr_ptr);
    end
    masked_valid = req_valid & above_mask;
    req_ready    = (|masked_valid) ? lowest_set(masked_valid) : lowest_set(req_valid);
  end

  // Pointer follows the granted index; it holds when nothing is granted.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) rr_ptr_nxt = PTR_W'(i);
    end
  end

  // Pointer register; resets to the last index so requester 0 ranks first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= PTR_W'(NREQ - 1);
    else        rr_ptr <= rr_ptr_nxt;
  end
`else
  // Fixed priority grant: index 0 highest, lower indices may starve higher ones.
  always_comb begin
    req_ready = lowest_set(req_valid);
  end
`endif

  // Select the granted requester's destination and data for the commit stage.
  always_comb begin
    accept     = |req_ready;
    win_regsel = '0;
    win_data   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        win_regsel = req_regsel[i*REG_W +: REG_W];
        win_data   = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Commit stage: one-cycle write pulse per accept; regsel/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write       <= 1'b0;
      writeregsel <= '0;
      writedata   <= '0;
    end else begin
      write <= accept;
      if (accept) begin
        writeregsel <= win_regsel;
        writedata   <= win_data;
      end
    end
  end

  // Scoreboard next state: committing write clears, reservation sets, set applied last so it wins.
  always_comb begin
    busy_nxt = busy;
    if (write)     busy_nxt[writeregsel] = 1'b0;
    if (rsv_valid) busy_nxt[rsv_regsel]  = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign hazard = busy[chk1_regsel] | busy[chk2_regsel];

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Purpose: directed bench for rf_wb_ctrl with a commit scoreboard and a behavioural rf model.
// Latency: expected commits are queued at accept and matched against the write pulse one cycle later.
// Backpressure: none modelled; the DUT always grants one valid requester.
module tb_rf_wb_ctrl;
  localparam int NREQ   = 3;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef logic [REG_W+DATA_W-1:0] entry_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*REG_W-1:0]  req_regsel;
  logic [NREQ*DATA_W-1:0] req_data;
  logic                   rsv_valid;
  logic [REG_W-1:0]       rsv_regsel;
  logic [REG_W-1:0]       chk1_regsel;
  logic [REG_W-1:0]       chk2_regsel;
  logic                   hazard;
  logic [31:0]            busy;
  logic                   write;
  logic [REG_W-1:0]       writeregsel;
  logic [DATA_W-1:0]      writedata;

  logic [DATA_W-1:0]      rf_m [0:31];
  entry_t                 exp_q [$];
  entry_t                 mon_e;
  int                     checks = 0;
  int                     errors = 0;
  logic [NREQ-1:0]        g_all [4];
  logic [NREQ-1:0]        g_two [2];

  rf_wb_ctrl #(.NREQ(NREQ), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_regsel  (req_regsel),
    .req_data    (req_data),
    .rsv_valid   (rsv_valid),
    .rsv_regsel  (rsv_regsel),
    .chk1_regsel (chk1_regsel),
    .chk2_regsel (chk2_regsel),
    .hazard      (hazard),
    .busy        (busy),
    .write       (write),
    .writeregsel (writeregsel),
    .writedata   (writedata)
  );

  always #5 clk = ~clk;

  // Behavioural register file driven by the DUT write port.
  always @(posedge clk) begin
    if (write === 1'b1) rf_m[writeregsel] <= writedata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write pulse must match the oldest queued accept.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && write === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("write_without_accept", {63'b0, write}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("commit", {27'b0, writeregsel, writedata}, {27'b0, mon_e});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
    req_regsel[i*REG_W +: REG_W]   = r;
    req_data[i*DATA_W +: DATA_W]   = d;
  endtask

  // Check the grant, queue the expected commit, clock, then give the winner fresh data.
  task automatic step(input logic [NREQ-1:0] exp_rdy, input bit commit_expected);
    #1;
    check("req_ready", {61'b0, req_ready}, {61'b0, exp_rdy});
    for (int i = 0; i < NREQ; i++) begin
      if (exp_rdy[i] && commit_expected)
        exp_q.push_back({req_regsel[i*REG_W +: REG_W], req_data[i*DATA_W +: DATA_W]});
    end
    tick();
    for (int i = 0; i < NREQ; i++) begin
      if (exp_rdy[i]) req_data[i*DATA_W +: DATA_W] = req_data[i*DATA_W +: DATA_W] + 32'd1;
    end
  endtask

  initial begin
`ifdef RF_WB_RR_EN
    g_all[0] = 3'b001; g_all[1] = 3'b010; g_all[2] = 3'b100; g_all[3] = 3'b001;
    g_two[0] = 3'b010; g_two[1] = 3'b100;
`else
    g_all[0] = 3'b001; g_all[1] = 3'b001; g_all[2] = 3'b001; g_all[3] = 3'b001;
    g_two[0] = 3'b010; g_two[1] = 3'b010;
`endif
    rst_n       = 1'b0;
    req_valid   = 3'b111;
    req_regsel  = '0;
    req_data    = '0;
    rsv_valid   = 1'b0;
    rsv_regsel  = '0;
    chk1_regsel = '0;
    chk2_regsel = '0;
    set_req(0, 5'd1, 32'hA000_0000);
    set_req(1, 5'd2, 32'hB000_0000);
    set_req(2, 5'd3, 32'hC000_0000);

    // Reset held with all requesters valid.
    repeat (3) tick();
    check("rst_write", {63'b0, write}, 64'd0);
    check("rst_busy", {32'b0, busy}, 64'd0);
    check("rst_writeregsel", {59'b0, writeregsel}, 64'd0);
    check("rst_writedata", {32'b0, writedata}, 64'd0);
    rst_n = 1'b1;

    // Contention: all valid, then requester 0 drops.
    for (int k = 0; k < 4; k++) step(g_all[k], 1'b1);
    req_valid = 3'b110;
    for (int k = 0; k < 2; k++) step(g_two[k], 1'b1);
    req_valid = 3'b000;
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);

    // Single request from requester 1.
    set_req(1, 5'd5, 32'hDEAD_BEEF);
    req_valid = 3'b010;
    step(3'b010, 1'b1);
    req_valid = 3'b000;
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);
    check("rf_reg5", {32'b0, rf_m[5]}, {32'b0, 32'hDEAD_BEEF});

    // Scoreboard: reserve 7, then requester 2 writes 7.
    rsv_valid   = 1'b1;
    rsv_regsel  = 5'd7;
    chk1_regsel = 5'd7;
    chk2_regsel = 5'd0;
    #1;
    check("hazard_before_rsv", {63'b0, hazard}, 64'd0);
    tick();
    rsv_valid = 1'b0;
    #1;
    check("hazard_after_rsv", {63'b0, hazard}, 64'd1);
    check("busy_after_rsv", {32'b0, busy}, 64'h80);
    chk1_regsel = 5'd0;
    chk2_regsel = 5'd7;
    #1;
    check("hazard_chk2", {63'b0, hazard}, 64'd1);
    chk1_regsel = 5'd7;
    chk2_regsel = 5'd3;
    set_req(2, 5'd7, 32'hC0FF_EE00);
    req_valid = 3'b100;
    step(3'b100, 1'b1);
    req_valid = 3'b000;
    #1;
    check("hazard_commit_cycle", {63'b0, hazard}, 64'd1);
    tick();
    #1;
    check("hazard_cleared", {63'b0, hazard}, 64'd0);
    check("busy_cleared", {32'b0, busy}, 64'd0);

    // Same-edge set and clear of register 9.
    set_req(0, 5'd9, 32'h0909_0909);
    req_valid = 3'b001;
    step(3'b001, 1'b1);
    req_valid  = 3'b000;
    rsv_valid  = 1'b1;
    rsv_regsel = 5'd9;
    tick();
    rsv_valid   = 1'b0;
    chk1_regsel = 5'd9;
    #1;
    check("busy_set_wins", {32'b0, busy}, 64'h200);
    check("hazard_set_wins", {63'b0, hazard}, 64'd1);

    // Mid-operation reset discards the staged write.
    set_req(1, 5'd12, 32'h1111_2222);
    req_valid = 3'b010;
    step(3'b010, 1'b1);
    req_valid = 3'b000;
    tick();
    tick();
    check("rf_reg12_first", {32'b0, rf_m[12]}, {32'b0, 32'h1111_2222});
    set_req(1, 5'd12, 32'h3333_4444);
    req_valid = 3'b010;
    step(3'b010, 1'b0);
    req_valid = 3'b000;
    #1;
    check("staged_write", {63'b0, write}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_write", {63'b0, write}, 64'd0);
    check("midrst_busy", {32'b0, busy}, 64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("rf_reg12_kept", {32'b0, rf_m[12]}, {32'b0, 32'h1111_2222});
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
